fifo_burst_ctrl: RTL and testbench

Controller that shares the write port of the 64x8 FIFO between two byte producers and sequences its read port in 16-beat bursts toward a single consumer. Sits directly around the FIFO instance: it drives `wr_en`/`data_in`/`rd_en`, consumes the FIFO's coarse `full`/`empty` threshold flags and `data_o`, and keeps its own exact occupancy count for flush draining.

---
 rtl/fifo_ctrl_pkg.sv | 14 +
 rtl/rr_arb2.sv | 28 ++
 rtl/fifo_burst_ctrl.sv | 138 +++++++++++++
 tb/tb_fifo_burst_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared types and FIFO threshold constants for the burst FIFO controller.
package fifo_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BURST,
      FLUSH
   } rd_state_t;

   localparam int unsigned FIFO_DEPTH = 64;
   localparam int unsigned EMPTY_THR  = 16;
   localparam int unsigned FULL_THR   = 48;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the grant pointer moves only when advance is high.
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   // 1 means requester 1 was granted most recently
   logic last_grant;

   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = last_grant ? 2'b01 : 2'b10;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= 1'b1;
      end else if (advance && (gnt != 2'b00)) begin
         last_grant <= gnt[1];
      end
   end

endmodule

// File: rtl/fifo_burst_ctrl.sv
// Arbitrates two byte producers onto the FIFO write port and drains the read
// port toward one consumer in fixed-length bursts, or completely on flush.
module fifo_burst_ctrl
   import fifo_ctrl_pkg::*;
#(
   parameter int unsigned BURST_LEN = EMPTY_THR,
   parameter int unsigned DEPTH     = FIFO_DEPTH
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in0_valid,
   input  logic [7:0] in0_data,
   output logic       in0_ready,
   input  logic       in1_valid,
   input  logic [7:0] in1_data,
   output logic       in1_ready,
   input  logic       flush,
   output logic       flush_done,
   output logic       out_valid,
   output logic [7:0] out_data,
   input  logic       out_ready,
   output logic       fifo_wr_en,
   output logic       fifo_rd_en,
   output logic [7:0] fifo_wdata,
   input  logic [7:0] fifo_rdata,
   input  logic       fifo_full,
   input  logic       fifo_empty
);

   localparam int unsigned OW = $clog2(DEPTH) + 1;
   localparam int unsigned BW = $clog2(BURST_LEN) + 1;

   rd_state_t     state;
   logic [OW-1:0] occ;
   logic [BW-1:0] beats;
   logic [1:0]    gnt;
   logic          wr_block;
   logic          rd_ok;
   logic          rd_pend;
   logic          skid_full;
   logic [7:0]    skid;

   rr_arb2 u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     ({in1_valid, in0_valid}),
      .advance (fifo_wr_en),
      .gnt     (gnt)
   );

   assign wr_block   = reset || fifo_full || (state == FLUSH);
   assign in0_ready  = gnt[0] && !wr_block;
   assign in1_ready  = gnt[1] && !wr_block;
   assign fifo_wr_en = (in0_valid && in0_ready) || (in1_valid && in1_ready);
   assign fifo_wdata = gnt[1] ? in1_data : in0_data;

   assign out_valid = skid_full || rd_pend;
   assign out_data  = skid_full ? skid : fifo_rdata;
   // A read may issue only if the beat it produces is guaranteed a slot:
   // either the output drains this cycle or nothing is currently presented.
   // This keeps at most one beat between in-flight and skid, so none is lost.
   assign rd_ok = out_ready || !out_valid;

   always_comb begin
      fifo_rd_en = 1'b0;
      if (!reset) begin
         unique case (state)
            BURST:   fifo_rd_en = rd_ok;
            FLUSH:   fifo_rd_en = rd_ok && (occ != '0);
            default: fifo_rd_en = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         beats      <= '0;
         flush_done <= 1'b0;
      end else begin
         flush_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (flush) begin
                  state <= FLUSH;
               end else if (!fifo_empty) begin
                  state <= BURST;
                  beats <= BW'(BURST_LEN);
               end
            end
            BURST: begin
               if (fifo_rd_en) begin
                  beats <= beats - BW'(1);
                  if (beats == BW'(1)) begin
                     state <= IDLE;
                  end
               end
            end
            FLUSH: begin
               if ((occ == '0) && !rd_pend && !skid_full) begin
                  flush_done <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         occ <= '0;
      end else begin
         unique case ({fifo_wr_en, fifo_rd_en})
            2'b10:   occ <= occ + OW'(1);
            2'b01:   occ <= occ - OW'(1);
            default: occ <= occ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_pend   <= 1'b0;
         skid_full <= 1'b0;
         skid      <= '0;
      end else begin
         rd_pend <= fifo_rd_en;
         if (rd_pend && !out_ready) begin
            skid_full <= 1'b1;
            skid      <= fifo_rdata;
         end else if (skid_full && out_ready) begin
            skid_full <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fifo_burst_ctrl.sv
// Self-checking bench for fifo_burst_ctrl with a behavioural 64x8 FIFO around it.
module tb_fifo_burst_ctrl;
   import fifo_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in0_valid = 1'b0, in1_valid = 1'b0;
   logic [7:0] in0_data = '0, in1_data = '0;
   logic       in0_ready, in1_ready;
   logic       flush = 1'b0, flush_done;
   logic       out_valid, out_ready = 1'b1;
   logic [7:0] out_data;
   logic       fifo_wr_en, fifo_rd_en, fifo_full, fifo_empty;
   logic [7:0] fifo_wdata, fifo_rdata;

   always #5 clk = ~clk;

   fifo_burst_ctrl #(.BURST_LEN(16), .DEPTH(FIFO_DEPTH)) u_dut (
      .clk(clk), .reset(reset),
      .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
      .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
      .flush(flush), .flush_done(flush_done),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en), .fifo_wdata(fifo_wdata),
      .fifo_rdata(fifo_rdata), .fifo_full(fifo_full), .fifo_empty(fifo_empty)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural FIFO: registered read data, threshold flags from true count.
   logic [7:0] mem [FIFO_DEPTH];
   int fcnt = 0, wp = 0, rp = 0;
   assign fifo_full  = fcnt >= int'(FULL_THR);
   assign fifo_empty = fcnt <= int'(EMPTY_THR);

   always @(posedge clk) begin
      if (reset) begin
         fcnt <= 0; wp <= 0; rp <= 0;
         fifo_rdata <= 8'($urandom);
      end else begin
         if (fifo_rd_en) begin
            fifo_rdata <= mem[rp];
            rp <= (rp + 1) % FIFO_DEPTH;
         end else begin
            fifo_rdata <= 8'($urandom);
         end
         if (fifo_wr_en) begin
            mem[wp] <= fifo_wdata;
            wp <= (wp + 1) % FIFO_DEPTH;
         end
         fcnt <= fcnt + (fifo_wr_en ? 1 : 0) - (fifo_rd_en ? 1 : 0);
      end
   end

   // Scoreboard, statistics and arbitration reference model
   logic [7:0] q[$];
   int  cyc = 0;
   int  out_count, accepted, flush_done_count;
   int  first_valid, first_hs, last_hs, empty_fall;
   bit  rr_check_en = 1'b0;
   bit  mlast = 1'b1;
   bit  toggle_rdy = 1'b0, rand_rdy = 1'b0;
   int  rdy_pct = 50;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (reset) begin
         q.delete();
         mlast = 1'b1;
      end else begin
         if (out_valid && out_ready) begin
            logic [8:0] exp_b;
            exp_b = (q.size() > 0) ? {1'b0, q.pop_front()} : 9'h100;
            chk("out_data_order", {1'b0, out_data}, exp_b);
            out_count++;
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
         end
         if (out_valid && first_valid < 0) first_valid = cyc;
         if (!fifo_empty && empty_fall < 0) empty_fall = cyc;
         if (flush_done) flush_done_count++;
         if (fifo_rd_en) chk("rd_within_occ", (fcnt > 0) ? 1 : 0, 1);
         if (fifo_wr_en) chk("no_write_at_full", fifo_full, 0);
         if (rr_check_en) begin
            int g;
            bit e0, e1;
            g = -1;
            if (in0_valid && in1_valid) g = mlast ? 0 : 1;
            else if (in0_valid) g = 0;
            else if (in1_valid) g = 1;
            e0 = (g == 0) && (fcnt < int'(FULL_THR));
            e1 = (g == 1) && (fcnt < int'(FULL_THR));
            chk("model_in0_ready", in0_ready, e0);
            chk("model_in1_ready", in1_ready, e1);
            chk("model_wr_en", fifo_wr_en, e0 || e1);
            chk("model_occ", u_dut.occ, fcnt);
            if (e0 || e1) mlast = (g == 1);
         end
         if (in0_valid && in0_ready) begin q.push_back(in0_data); accepted++; end
         if (in1_valid && in1_ready) begin q.push_back(in1_data); accepted++; end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (toggle_rdy) out_ready = ~out_ready;
      else if (rand_rdy) out_ready = ($urandom % 100) < rdy_pct;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      in0_valid = 1'b0; in1_valid = 1'b0; flush = 1'b0;
      toggle_rdy = 1'b0; rand_rdy = 1'b0; out_ready = 1'b1;
      tick(); tick();
      reset = 1'b0;
      out_count = 0; accepted = 0; flush_done_count = 0;
      first_valid = -1; first_hs = -1; last_hs = -1; empty_fall = -1;
      rr_check_en = 1'b1;
   endtask

   task automatic write_in0(input int n);
      in0_valid = 1'b1;
      for (int i = 0; i < n; i++) begin
         in0_data = 8'(i);
         tick();
      end
      in0_valid = 1'b0;
   endtask

   task automatic wait_outputs(input int n, input int bound);
      int w = 0;
      while (out_count < n && w < bound) begin tick(); w++; end
   endtask

   typedef struct {
      logic v0, v1; logic [7:0] d0, d1;
      logic r0, r1, wr; logic [7:0] wd;
   } vec_t;
   vec_t tbl[9];

   initial begin
      tbl[0] = '{1'b0, 1'b0, 8'hA0, 8'hB0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[1] = '{1'b1, 1'b1, 8'hA1, 8'hB1, 1'b1, 1'b0, 1'b1, 8'hA1};
      tbl[2] = '{1'b1, 1'b1, 8'hA2, 8'hB2, 1'b0, 1'b1, 1'b1, 8'hB2};
      tbl[3] = '{1'b0, 1'b1, 8'hA3, 8'hB3, 1'b0, 1'b1, 1'b1, 8'hB3};
      tbl[4] = '{1'b1, 1'b1, 8'hA4, 8'hB4, 1'b1, 1'b0, 1'b1, 8'hA4};
      tbl[5] = '{1'b1, 1'b0, 8'hA5, 8'hB5, 1'b1, 1'b0, 1'b1, 8'hA5};
      tbl[6] = '{1'b1, 1'b1, 8'hA6, 8'hB6, 1'b0, 1'b1, 1'b1, 8'hB6};
      tbl[7] = '{1'b0, 1'b0, 8'hA7, 8'hB7, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[8] = '{1'b1, 1'b1, 8'hA8, 8'hB8, 1'b1, 1'b0, 1'b1, 8'hA8};

      // Reset state, with both producers requesting
      in0_valid = 1'b1; in1_valid = 1'b1;
      tick(); tick();
      @(negedge clk);
      chk("rst_in0_ready", in0_ready, 0);
      chk("rst_in1_ready", in1_ready, 0);
      chk("rst_wr_en", fifo_wr_en, 0);
      chk("rst_rd_en", fifo_rd_en, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_flush_done", flush_done, 0);
      chk("rst_occ", u_dut.occ, 0);
      do_reset();

      // Arbitration vectors
      for (int i = 0; i < 9; i++) begin
         in0_valid = tbl[i].v0; in1_valid = tbl[i].v1;
         in0_data = tbl[i].d0;  in1_data = tbl[i].d1;
         @(negedge clk);
         chk("tbl_in0_ready", in0_ready, tbl[i].r0);
         chk("tbl_in1_ready", in1_ready, tbl[i].r1);
         chk("tbl_wr_en", fifo_wr_en, tbl[i].wr);
         if (tbl[i].wr) chk("tbl_wdata", fifo_wdata, tbl[i].wd);
         tick();
      end
      in0_valid = 1'b0; in1_valid = 1'b0;
      @(negedge clk);
      chk("tbl_occ", u_dut.occ, 7);
      tick();

      // Flush with bytes below the burst threshold
      begin
         int w = 0;
         bit done = 1'b0;
         flush = 1'b1;
         tick();
         flush = 1'b0;
         rr_check_en = 1'b0;
         in0_valid = 1'b1; in1_valid = 1'b1;
         while (!done && w < 100) begin
            @(negedge clk);
            if (flush_done) begin
               done = 1'b1;
               chk("flush_occ_zero", u_dut.occ, 0);
            end else begin
               chk("flush_in0_blocked", in0_ready, 0);
               chk("flush_in1_blocked", in1_ready, 0);
            end
            tick();
            w++;
         end
         in0_valid = 1'b0; in1_valid = 1'b0;
         repeat (5) tick();
         chk("flush_done_pulses", flush_done_count, 1);
         chk("flush_bytes_out", out_count, 7);
      end

      // Round-robin alternation, in0 first
      do_reset();
      in0_valid = 1'b1; in1_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in0_data = 8'(i); in1_data = 8'(8'h80 + i);
         @(negedge clk);
         chk("rr_alt_in0", in0_ready, (i % 2) == 0);
         chk("rr_alt_in1", in1_ready, (i % 2) == 1);
         tick();
      end
      in0_valid = 1'b0; in1_valid = 1'b0;

      // Write backpressure with the consumer stalled; one beat sits at the output
      do_reset();
      out_ready = 1'b0;
      write_in0(70);
      in0_valid = 1'b1;
      @(negedge clk);
      chk("bp_in0_ready", in0_ready, 0);
      chk("bp_fifo_full", fifo_full, 1);
      chk("bp_occ", u_dut.occ, FULL_THR);
      chk("bp_accepted", accepted, FULL_THR + 1);
      chk("bp_held_beat", out_valid, 1);
      tick();
      in0_valid = 1'b0;

      // Single burst: latency, throughput, residue
      do_reset();
      write_in0(20);
      wait_outputs(16, 100);
      repeat (10) tick();
      chk("burst_count", out_count, 16);
      chk("burst_latency", first_valid - empty_fall, 2);
      chk("burst_span", last_hs - first_hs, 15);
      chk("burst_left", q.size(), 4);
      @(negedge clk);
      chk("burst_occ", u_dut.occ, 4);
      tick();

      // Consumer stalls every other cycle
      do_reset();
      toggle_rdy = 1'b1;
      write_in0(20);
      wait_outputs(16, 200);
      toggle_rdy = 1'b0; out_ready = 1'b1;
      repeat (10) tick();
      chk("stall_count", out_count, 16);
      @(negedge clk);
      chk("stall_occ", u_dut.occ, 4);
      tick();

      // Reset in the middle of a burst
      do_reset();
      write_in0(20);
      wait_outputs(7, 100);
      chk("mid_beats_seen", out_count, 7);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("mid_out_valid", out_valid, 0);
      chk("mid_rd_en", fifo_rd_en, 0);
      chk("mid_wr_en", fifo_wr_en, 0);
      chk("mid_flush_done", flush_done, 0);
      chk("mid_in0_ready", in0_ready, 0);
      chk("mid_occ", u_dut.occ, 0);
      chk("mid_state", u_dut.state, IDLE);
      tick();

      // Randomised traffic against the scoreboard and arbitration model
      do_reset();
      rand_rdy = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         rdy_pct = ((i / 500) % 2 == 1) ? 85 : 20;
         in0_valid = ($urandom % 4) != 0;
         in1_valid = ($urandom % 3) == 0;
         in0_data = 8'($urandom);
         in1_data = 8'($urandom);
         tick();
      end
      in0_valid = 1'b0; in1_valid = 1'b0;
      rand_rdy = 1'b0; out_ready = 1'b1;
      begin
         int w = 0;
         bit done = 1'b0;
         flush = 1'b1;
         while (!done && w < 400) begin
            @(negedge clk);
            if (flush_done) begin
               done = 1'b1;
               flush = 1'b0;
            end
            tick();
            w++;
         end
         flush = 1'b0;
         repeat (5) tick();
         chk("final_flush_done", flush_done_count, 1);
         chk("final_queue_empty", q.size(), 0);
         chk("final_all_out", out_count, accepted);
         @(negedge clk);
         chk("final_occ", u_dut.occ, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
